fetch_prefetch_buffer: RTL and testbench

Parametrised prefetch unit between the IF-stage PC logic and the instruction-memory OBI port. It issues sequential word fetches ahead of the core, limits the number of outstanding bus transactions, and buffers returned words with their addresses in a DEPTH-entry FIFO. On a PC redirect (branch/jump/first `pc_set`) it flushes the FIFO and silently drops responses to requests granted before the redirect.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_prefetch_buffer_if.sv | 30 +++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_prefetch_buffer.sv | 178 +++++++++++++++++
 tb/tb_fetch_prefetch_buffer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetch buffer.
// FSM states, FIFO entry layout and fetch stride.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam int unsigned ADDR_INC = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        BRANCH_WAIT
    } fsm_state_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_buffer_if.sv
// OBI instruction-memory port bundle.
// master = prefetcher, slave = memory.
interface fetch_prefetch_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              instr_req;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_gnt;
    logic              instr_rvalid;
    logic [DATA_W-1:0] instr_rdata;

    modport master (
        output instr_req,
        output instr_addr,
        input  instr_gnt,
        input  instr_rvalid,
        input  instr_rdata
    );

    modport slave (
        input  instr_req,
        input  instr_addr,
        output instr_gnt,
        output instr_rvalid,
        output instr_rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// Circular FIFO of fetched {addr, data} entries.
// Clear wins over push/pop; head reads zero when empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  entry_t                     wdata_i,
    input  logic                       pop_i,
    output entry_t                     rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_q;
    logic [PW-1:0]   rd_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign count_d = count_q + CW'(push_i) - CW'(pop_i);
    assign count_o = count_q;
    assign rdata_o = (count_q != '0) ? mem_q[rd_q] : '0;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= ptr_inc(wr_q);
            if (pop_i)  rd_q <= ptr_inc(rd_q);
            count_q <= count_d;
        end
    end

    // Storage write; contents beyond count are don't-care.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Sequential instruction prefetcher with outstanding-request limit.
// Redirects flush the FIFO and drop responses already in flight.
module fetch_prefetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_i,
    input  logic                 branch_i,
    input  logic [ADDR_W-1:0]    branch_addr_i,
    input  logic                 fetch_ready_i,
    output logic                 fetch_valid_o,
    output logic [DATA_W-1:0]    fetch_rdata_o,
    output logic [ADDR_W-1:0]    fetch_addr_o,
    fetch_prefetch_buffer_if.master obi,
    output logic                 busy_o
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    fsm_state_e        state_q;
    logic [ADDR_W-1:0] next_addr_q;
    logic [ADDR_W-1:0] target_q;
    logic [ADDR_W-1:0] push_addr_q;
    logic [OW-1:0]     live_q;
    logic [OW-1:0]     live_d;
    logic [OW-1:0]     disc_q;
    logic [OW-1:0]     disc_d;
    logic [CW-1:0]     count;

    logic              credit;
    logic              req;
    logic              gnt;
    logic              rv_ok;
    logic              keep;
    logic              drop;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] tgt;
    entry_t            wr_entry;
    entry_t            head;

    assign tgt = branch_addr_i & ~ADDR_W'(3);

    assign credit = (int'(live_q) + int'(disc_q) < MAX_OUTSTANDING)
                 && (int'(count) + int'(live_q) < DEPTH);

    // Request decode from registered state.
    always_comb begin
        req = 1'b0;
        unique case (state_q)
            IDLE:        req = 1'b0;
            RUN:         req = req_i & credit;
            BRANCH_WAIT: req = 1'b1;
            default:     req = 1'b0;
        endcase
    end

    assign obi.instr_req  = req;
    assign obi.instr_addr = next_addr_q;
    assign gnt            = req & obi.instr_gnt;

    // Responses with nothing in flight (e.g. after reset) are ignored.
    assign rv_ok = obi.instr_rvalid & ((live_q != '0) | (disc_q != '0));
    assign drop  = rv_ok & (disc_q != '0);
    assign keep  = rv_ok & (disc_q == '0);

    assign push = keep & ~branch_i;
    assign pop  = fetch_valid_o & fetch_ready_i;

    assign fetch_valid_o = (count != '0) & ~branch_i;
    assign fetch_addr_o  = head.addr;
    assign fetch_rdata_o = head.data;

    assign busy_o = req | (live_q != '0) | (disc_q != '0);

    // Next-state for kept/dropped transaction counters.
    always_comb begin
        live_d = live_q;
        disc_d = disc_q;
        if (branch_i) begin
            live_d = '0;
            disc_d = disc_q + live_q + OW'(gnt) - OW'(rv_ok);
        end else begin
            if (gnt && state_q == RUN)         live_d = live_d + OW'(1);
            if (keep)                          live_d = live_d - OW'(1);
            if (gnt && state_q == BRANCH_WAIT) disc_d = disc_d + OW'(1);
            if (drop)                          disc_d = disc_d - OW'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            live_q <= '0;
            disc_q <= '0;
        end else begin
            live_q <= live_d;
            disc_q <= disc_d;
        end
    end

    // Fetch FSM: address sequencing and redirect handling.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            next_addr_q <= '0;
            target_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (branch_i) begin
                        state_q     <= RUN;
                        next_addr_q <= tgt;
                    end
                end
                RUN: begin
                    if (branch_i && req && !obi.instr_gnt) begin
                        state_q  <= BRANCH_WAIT;
                        target_q <= tgt;
                    end else if (branch_i) begin
                        next_addr_q <= tgt;
                    end else if (gnt) begin
                        next_addr_q <= next_addr_q + ADDR_W'(ADDR_INC);
                    end
                end
                BRANCH_WAIT: begin
                    if (gnt) begin
                        state_q     <= RUN;
                        next_addr_q <= branch_i ? tgt : target_q;
                    end else if (branch_i) begin
                        target_q <= tgt;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Address tag for kept responses; reloaded on redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            push_addr_q <= '0;
        end else if (branch_i) begin
            push_addr_q <= tgt;
        end else if (push) begin
            push_addr_q <= push_addr_q + ADDR_W'(ADDR_INC);
        end
    end

    assign wr_entry = '{addr: push_addr_q, data: obi.instr_rdata};

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (branch_i),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count)
    );

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer.
// Inputs change on the falling edge; a small memory model answers grants.
module tb_fetch_prefetch_buffer;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        fetch_ready_i;
    logic        fetch_valid_o;
    logic [31:0] fetch_rdata_o;
    logic [31:0] fetch_addr_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;
    bit auto_rsp;
    logic [31:0] pend[$];

    always #10 clk = ~clk;

    fetch_prefetch_buffer_if #(.ADDR_W(32), .DATA_W(32)) obi ();

    fetch_prefetch_buffer #(
        .DEPTH           (4),
        .MAX_OUTSTANDING (2),
        .ADDR_W          (32),
        .DATA_W          (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .fetch_ready_i (fetch_ready_i),
        .fetch_valid_o (fetch_valid_o),
        .fetch_rdata_o (fetch_rdata_o),
        .fetch_addr_o  (fetch_addr_o),
        .obi           (obi.master),
        .busy_o        (busy_o)
    );

    function automatic logic [31:0] md(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: record grants, retire responses, drive auto responses.
    task automatic tick;
        logic        g;
        logic        rv;
        logic [31:0] a;
        #1;
        g  = obi.instr_req & obi.instr_gnt;
        a  = obi.instr_addr;
        rv = obi.instr_rvalid;
        @(posedge clk);
        @(negedge clk);
        if (rv && pend.size() > 0) void'(pend.pop_front());
        if (g && !rst) pend.push_back(a);
        if (auto_rsp && pend.size() > 0) begin
            obi.instr_rvalid = 1'b1;
            obi.instr_rdata  = md(pend[0]);
        end else begin
            obi.instr_rvalid = 1'b0;
            obi.instr_rdata  = 32'h0;
        end
    endtask

    initial begin
        rst = 1'b1; req_i = 1'b0; branch_i = 1'b0;
        branch_addr_i = 32'h0; fetch_ready_i = 1'b0;
        obi.instr_gnt = 1'b0; obi.instr_rvalid = 1'b0;
        obi.instr_rdata = 32'h0; auto_rsp = 1'b0;
        tick; tick;
        rst = 1'b0;
        #1;
        chk("rst_req",   32'(obi.instr_req), 32'h0);
        chk("rst_addr",  obi.instr_addr,     32'h0);
        chk("rst_valid", 32'(fetch_valid_o), 32'h0);
        chk("rst_rdata", fetch_rdata_o,      32'h0);
        chk("rst_faddr", fetch_addr_o,       32'h0);
        chk("rst_busy",  32'(busy_o),        32'h0);

        // Fill to DEPTH from 0x100 (low bits of target ignored).
        req_i = 1'b1; obi.instr_gnt = 1'b1; auto_rsp = 1'b1;
        branch_i = 1'b1; branch_addr_i = 32'h0000_0103;
        tick;
        branch_i = 1'b0;
        #1;
        chk("t1_req",  32'(obi.instr_req), 32'h1);
        chk("t1_addr", obi.instr_addr,     32'h100);
        tick; tick; tick; tick; tick;
        #1;
        chk("t1_full_valid", 32'(fetch_valid_o), 32'h1);
        chk("t1_full_noreq", 32'(obi.instr_req), 32'h0);
        req_i = 1'b0; fetch_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t1_pop_addr", fetch_addr_o, 32'h100 + 32'(4 * i));
            chk("t1_pop_data", fetch_rdata_o, md(32'h100 + 32'(4 * i)));
            tick;
        end
        fetch_ready_i = 1'b0;
        #1;
        chk("t1_empty", 32'(fetch_valid_o), 32'h0);

        // Grant stall: request and address must hold.
        branch_i = 1'b1; branch_addr_i = 32'h200; obi.instr_gnt = 1'b0;
        tick;
        branch_i = 1'b0; req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_stall_req",  32'(obi.instr_req), 32'h1);
            chk("t2_stall_addr", obi.instr_addr,     32'h200);
            tick;
        end
        obi.instr_gnt = 1'b1;
        #1;
        chk("t2_gnt_addr", obi.instr_addr, 32'h200);
        tick;
        obi.instr_gnt = 1'b0;
        tick;
        #1;
        chk("t2_valid", 32'(fetch_valid_o), 32'h1);
        chk("t2_faddr", fetch_addr_o,       32'h200);
        chk("t2_fdata", fetch_rdata_o,      md(32'h200));
        fetch_ready_i = 1'b1;
        tick;
        fetch_ready_i = 1'b0;

        // Two in flight then redirect: both responses dropped.
        req_i = 1'b0; branch_i = 1'b1; branch_addr_i = 32'h300;
        tick;
        branch_i = 1'b0; req_i = 1'b1; obi.instr_gnt = 1'b1; auto_rsp = 1'b0;
        tick; tick;
        #1;
        chk("t3_limit_req", 32'(obi.instr_req), 32'h0);
        chk("t3_busy",      32'(busy_o),        32'h1);
        branch_i = 1'b1; branch_addr_i = 32'h400;
        tick;
        branch_i = 1'b0;
        #1;
        chk("t3_drain_noreq", 32'(obi.instr_req), 32'h0);
        auto_rsp = 1'b1;
        tick; tick; tick; tick;
        req_i = 1'b0; obi.instr_gnt = 1'b0;
        tick;
        #1;
        chk("t3_valid", 32'(fetch_valid_o), 32'h1);
        chk("t3_faddr", fetch_addr_o,       32'h400);
        chk("t3_fdata", fetch_rdata_o,      md(32'h400));
        fetch_ready_i = 1'b1;
        tick;
        #1;
        chk("t3_faddr2", fetch_addr_o,  32'h404);
        chk("t3_fdata2", fetch_rdata_o, md(32'h404));
        tick;
        fetch_ready_i = 1'b0;
        #1;
        chk("t3_empty", 32'(fetch_valid_o), 32'h0);
        chk("t3_idle",  32'(busy_o),        32'h0);

        // Redirect while 0x500 is ungranted.
        branch_i = 1'b1; branch_addr_i = 32'h500;
        tick;
        branch_i = 1'b0; req_i = 1'b1; obi.instr_gnt = 1'b0;
        #1;
        chk("t4_req",  32'(obi.instr_req), 32'h1);
        chk("t4_addr", obi.instr_addr,     32'h500);
        branch_i = 1'b1; branch_addr_i = 32'h600;
        tick;
        branch_i = 1'b0;
        #1;
        chk("t4_state_bw", 32'(dut.state_q), 32'(BRANCH_WAIT));
        chk("t4_bw_req",   32'(obi.instr_req), 32'h1);
        chk("t4_bw_addr",  obi.instr_addr,     32'h500);
        tick;
        #1;
        chk("t4_bw_hold", obi.instr_addr, 32'h500);
        obi.instr_gnt = 1'b1;
        tick;
        obi.instr_gnt = 1'b0;
        #1;
        chk("t4_state_run", 32'(dut.state_q), 32'(RUN));
        chk("t4_tgt_req",   32'(obi.instr_req), 32'h1);
        chk("t4_tgt_addr",  obi.instr_addr,     32'h600);
        tick;
        obi.instr_gnt = 1'b1;
        tick;
        obi.instr_gnt = 1'b0; req_i = 1'b0;
        tick;
        #1;
        chk("t4_valid", 32'(fetch_valid_o), 32'h1);
        chk("t4_faddr", fetch_addr_o,       32'h600);
        chk("t4_fdata", fetch_rdata_o,      md(32'h600));
        fetch_ready_i = 1'b1;
        tick;
        fetch_ready_i = 1'b0;
        #1;
        chk("t4_empty", 32'(fetch_valid_o), 32'h0);
        chk("t4_idle",  32'(busy_o),        32'h0);

        // Response and redirect in the same cycle with FIFO filling.
        branch_i = 1'b1; branch_addr_i = 32'h700;
        tick;
        branch_i = 1'b0; req_i = 1'b1; obi.instr_gnt = 1'b1;
        tick; tick; tick; tick;
        #1;
        chk("t5_valid",  32'(fetch_valid_o), 32'h1);
        chk("t5_noreq",  32'(obi.instr_req), 32'h0);
        chk("t5_faddr",  fetch_addr_o,       32'h700);
        branch_i = 1'b1; branch_addr_i = 32'h800; fetch_ready_i = 1'b1;
        #1;
        chk("t5_rv_same", 32'(obi.instr_rvalid), 32'h1);
        chk("t5_redir_valid", 32'(fetch_valid_o), 32'h0);
        tick;
        branch_i = 1'b0; fetch_ready_i = 1'b0;
        #1;
        chk("t5_flushed", 32'(fetch_valid_o), 32'h0);
        chk("t5_new_req", 32'(obi.instr_req), 32'h1);
        chk("t5_new_addr", obi.instr_addr,    32'h800);

        // Reset with two transactions outstanding.
        auto_rsp = 1'b0;
        tick; tick;
        #1;
        chk("t6_busy",  32'(busy_o),        32'h1);
        chk("t6_limit", 32'(obi.instr_req), 32'h0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        chk("t6_req",   32'(obi.instr_req), 32'h0);
        chk("t6_addr",  obi.instr_addr,     32'h0);
        chk("t6_valid", 32'(fetch_valid_o), 32'h0);
        chk("t6_rdata", fetch_rdata_o,      32'h0);
        chk("t6_faddr", fetch_addr_o,       32'h0);
        chk("t6_nobusy", 32'(busy_o),       32'h0);
        pend.delete();
        obi.instr_rvalid = 1'b1; obi.instr_rdata = 32'hDEAD_BEEF;
        tick;
        #1;
        chk("t6_late_valid", 32'(fetch_valid_o), 32'h0);
        chk("t6_late_busy",  32'(busy_o),        32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
